// File: rtl/rx_cmd_parser.sv
// UART byte-stream command parser: assembles AA/BB/CC/DD frames into
// register-file and ALU strobes, with command, address and timeout checking.
module rx_cmd_parser #(
    parameter int ADDR_W   = 4,
    parameter int TIMEOUT  = 2048,
    parameter int OPA_ADDR = 0,
    parameter int OPB_ADDR = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [7:0]        P_DATA,
    input  logic              DATA_VALID,
    output logic              RF_WrEn,
    output logic              RF_RdEn,
    output logic [ADDR_W-1:0] RF_Address,
    output logic [7:0]        RF_WrData,
    output logic              ALU_EN,
    output logic [3:0]        ALU_FUN,
    output logic              BUSY,
    output logic              CMD_ERR,
    output logic              FRAME_ERR
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] A_OPA    = ADDR_W'(OPA_ADDR);
    localparam logic [ADDR_W-1:0] A_OPB    = ADDR_W'(OPB_ADDR);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_ADDR,
        S_WR_DATA,
        S_RD_ADDR,
        S_OPA,
        S_OPB,
        S_ALU_FUN
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [7:0]        w_addr_hi;
    logic              w_addr_ok;

    assign w_addr_hi = P_DATA >> ADDR_W;
    assign w_addr_ok = (w_addr_hi == 8'd0);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_wr_addr  <= '0;
            RF_WrEn    <= 1'b0;
            RF_RdEn    <= 1'b0;
            RF_Address <= '0;
            RF_WrData  <= '0;
            ALU_EN     <= 1'b0;
            ALU_FUN    <= '0;
            BUSY       <= 1'b0;
            CMD_ERR    <= 1'b0;
            FRAME_ERR  <= 1'b0;
        end else begin
            RF_WrEn   <= 1'b0;
            RF_RdEn   <= 1'b0;
            ALU_EN    <= 1'b0;
            CMD_ERR   <= 1'b0;
            FRAME_ERR <= 1'b0;
            if (DATA_VALID) begin
                // A byte always wins over an expiring timeout.
                r_cnt <= '0;
                unique case (r_state)
                    S_IDLE: begin
                        case (P_DATA)
                            8'hAA: begin r_state <= S_WR_ADDR; BUSY <= 1'b1; end
                            8'hBB: begin r_state <= S_RD_ADDR; BUSY <= 1'b1; end
                            8'hCC: begin r_state <= S_OPA;     BUSY <= 1'b1; end
                            8'hDD: begin r_state <= S_ALU_FUN; BUSY <= 1'b1; end
                            default: CMD_ERR <= 1'b1;
                        endcase
                    end
                    S_WR_ADDR: begin
                        if (w_addr_ok) begin
                            r_wr_addr <= P_DATA[ADDR_W-1:0];
                            r_state   <= S_WR_DATA;
                        end else begin
                            FRAME_ERR <= 1'b1;
                            r_state   <= S_IDLE;
                            BUSY      <= 1'b0;
                        end
                    end
                    S_WR_DATA: begin
                        RF_WrEn    <= 1'b1;
                        RF_Address <= r_wr_addr;
                        RF_WrData  <= P_DATA;
                        r_state    <= S_IDLE;
                        BUSY       <= 1'b0;
                    end
                    S_RD_ADDR: begin
                        if (w_addr_ok) begin
                            RF_RdEn    <= 1'b1;
                            RF_Address <= P_DATA[ADDR_W-1:0];
                        end else begin
                            FRAME_ERR <= 1'b1;
                        end
                        r_state <= S_IDLE;
                        BUSY    <= 1'b0;
                    end
                    S_OPA: begin
                        RF_WrEn    <= 1'b1;
                        RF_Address <= A_OPA;
                        RF_WrData  <= P_DATA;
                        r_state    <= S_OPB;
                    end
                    S_OPB: begin
                        RF_WrEn    <= 1'b1;
                        RF_Address <= A_OPB;
                        RF_WrData  <= P_DATA;
                        r_state    <= S_ALU_FUN;
                    end
                    S_ALU_FUN: begin
                        ALU_EN  <= 1'b1;
                        ALU_FUN <= P_DATA[3:0];
                        r_state <= S_IDLE;
                        BUSY    <= 1'b0;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        BUSY    <= 1'b0;
                    end
                endcase
            end else if (r_state != S_IDLE) begin
                if (r_cnt == CNT_LAST) begin
                    FRAME_ERR <= 1'b1;
                    r_state   <= S_IDLE;
                    BUSY      <= 1'b0;
                    r_cnt     <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_rx_cmd_parser.sv
// Directed bench for rx_cmd_parser: per-cycle vector table on a short-timeout
// instance, plus a long-gap write sequence on a second instance.
module tb_rx_cmd_parser;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       DATA_VALID = 1'b0;
    logic [7:0] P_DATA = 8'h00;

    always #5 CLK = ~CLK;

    logic       wr, rd, alu, ce, fe, bz;
    logic [3:0] addr, fun;
    logic [7:0] wd;

    logic       wr2, rd2, alu2, ce2, fe2, bz2;
    logic [3:0] addr2, fun2;
    logic [7:0] wd2;

    rx_cmd_parser #(.ADDR_W(4), .TIMEOUT(8)) dut (
        .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .DATA_VALID(DATA_VALID),
        .RF_WrEn(wr), .RF_RdEn(rd), .RF_Address(addr), .RF_WrData(wd),
        .ALU_EN(alu), .ALU_FUN(fun), .BUSY(bz), .CMD_ERR(ce), .FRAME_ERR(fe)
    );

    rx_cmd_parser #(.ADDR_W(4), .TIMEOUT(32)) dut_long (
        .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .DATA_VALID(DATA_VALID),
        .RF_WrEn(wr2), .RF_RdEn(rd2), .RF_Address(addr2), .RF_WrData(wd2),
        .ALU_EN(alu2), .ALU_FUN(fun2), .BUSY(bz2), .CMD_ERR(ce2), .FRAME_ERR(fe2)
    );

    typedef struct {
        logic       rst;
        logic       dv;
        logic [7:0] d;
        logic       wr, rd, alu, ce, fe, bz;
        logic [3:0] a;
        logic [7:0] wd;
        logic [3:0] f;
    } vec_t;

    vec_t vq[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    function automatic void add(input logic r, input logic dv, input logic [7:0] d,
                                input logic e_wr, input logic e_rd, input logic e_alu,
                                input logic e_ce, input logic e_fe, input logic e_bz,
                                input logic [3:0] a, input logic [7:0] w,
                                input logic [3:0] f);
        vec_t v;
        v.rst = r; v.dv = dv; v.d = d;
        v.wr = e_wr; v.rd = e_rd; v.alu = e_alu;
        v.ce = e_ce; v.fe = e_fe; v.bz = e_bz;
        v.a = a; v.wd = w; v.f = f;
        vq.push_back(v);
    endfunction

    function automatic void idle(input int n, input logic e_bz, input logic [3:0] a,
                                 input logic [7:0] w, input logic [3:0] f);
        for (int i = 0; i < n; i++)
            add(0, 0, 8'h00, 0, 0, 0, 0, 0, e_bz, a, w, f);
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic dv, input logic [7:0] d);
        RST = r; DATA_VALID = dv; P_DATA = d;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        // rst dv data   wr rd alu ce fe bz  addr wdata fun
        add(1, 0, 8'h00, 0, 0, 0, 0, 0, 0, 4'h0, 8'h00, 4'h0);
        idle(1, 0, 4'h0, 8'h00, 4'h0);
        // CC 12 34 81 back-to-back
        add(0, 1, 8'hCC, 0, 0, 0, 0, 0, 1, 4'h0, 8'h00, 4'h0);
        add(0, 1, 8'h12, 1, 0, 0, 0, 0, 1, 4'h0, 8'h12, 4'h0);
        add(0, 1, 8'h34, 1, 0, 0, 0, 0, 1, 4'h1, 8'h34, 4'h0);
        add(0, 1, 8'h81, 0, 0, 1, 0, 0, 0, 4'h1, 8'h34, 4'h1);
        idle(1, 0, 4'h1, 8'h34, 4'h1);
        // BB 0F read, then DD 02 straight after
        add(0, 1, 8'hBB, 0, 0, 0, 0, 0, 1, 4'h1, 8'h34, 4'h1);
        add(0, 1, 8'h0F, 0, 1, 0, 0, 0, 0, 4'hF, 8'h34, 4'h1);
        add(0, 1, 8'hDD, 0, 0, 0, 0, 0, 1, 4'hF, 8'h34, 4'h1);
        add(0, 1, 8'h02, 0, 0, 1, 0, 0, 0, 4'hF, 8'h34, 4'h2);
        // unknown command, bad address, recovery write
        add(0, 1, 8'h55, 0, 0, 0, 1, 0, 0, 4'hF, 8'h34, 4'h2);
        add(0, 1, 8'hAA, 0, 0, 0, 0, 0, 1, 4'hF, 8'h34, 4'h2);
        add(0, 1, 8'h10, 0, 0, 0, 0, 1, 0, 4'hF, 8'h34, 4'h2);
        add(0, 1, 8'hAA, 0, 0, 0, 0, 0, 1, 4'hF, 8'h34, 4'h2);
        add(0, 1, 8'h02, 0, 0, 0, 0, 0, 1, 4'hF, 8'h34, 4'h2);
        add(0, 1, 8'h7E, 1, 0, 0, 0, 0, 0, 4'h2, 8'h7E, 4'h2);
        // timeout: 8th silent cycle raises FRAME_ERR
        add(0, 1, 8'hAA, 0, 0, 0, 0, 0, 1, 4'h2, 8'h7E, 4'h2);
        idle(7, 1, 4'h2, 8'h7E, 4'h2);
        add(0, 0, 8'h00, 0, 0, 0, 0, 1, 0, 4'h2, 8'h7E, 4'h2);
        idle(1, 0, 4'h2, 8'h7E, 4'h2);
        // byte on the terminal cycle is accepted
        add(0, 1, 8'hAA, 0, 0, 0, 0, 0, 1, 4'h2, 8'h7E, 4'h2);
        idle(7, 1, 4'h2, 8'h7E, 4'h2);
        add(0, 1, 8'h03, 0, 0, 0, 0, 0, 1, 4'h2, 8'h7E, 4'h2);
        idle(1, 1, 4'h2, 8'h7E, 4'h2);
        add(0, 1, 8'h44, 1, 0, 0, 0, 0, 0, 4'h3, 8'h44, 4'h2);
        // reset mid-frame, then DD 03
        add(0, 1, 8'hCC, 0, 0, 0, 0, 0, 1, 4'h3, 8'h44, 4'h2);
        add(0, 1, 8'h11, 1, 0, 0, 0, 0, 1, 4'h0, 8'h11, 4'h2);
        add(1, 0, 8'h00, 0, 0, 0, 0, 0, 0, 4'h0, 8'h00, 4'h0);
        add(0, 1, 8'hDD, 0, 0, 0, 0, 0, 1, 4'h0, 8'h00, 4'h0);
        add(0, 1, 8'h03, 0, 0, 1, 0, 0, 0, 4'h0, 8'h00, 4'h3);
        idle(2, 0, 4'h0, 8'h00, 4'h3);

        foreach (vq[i]) begin
            step(vq[i].rst, vq[i].dv, vq[i].d);
            check($sformatf("v%0d wr", i),    {7'd0, wr},  {7'd0, vq[i].wr});
            check($sformatf("v%0d rd", i),    {7'd0, rd},  {7'd0, vq[i].rd});
            check($sformatf("v%0d alu", i),   {7'd0, alu}, {7'd0, vq[i].alu});
            check($sformatf("v%0d cmderr", i),{7'd0, ce},  {7'd0, vq[i].ce});
            check($sformatf("v%0d frmerr", i),{7'd0, fe},  {7'd0, vq[i].fe});
            check($sformatf("v%0d busy", i),  {7'd0, bz},  {7'd0, vq[i].bz});
            check($sformatf("v%0d addr", i),  {4'd0, addr}, {4'd0, vq[i].a});
            check($sformatf("v%0d wdata", i), wd,           vq[i].wd);
            check($sformatf("v%0d fun", i),   {4'd0, fun},  {4'd0, vq[i].f});
            check($sformatf("v%0d excl", i),
                  8'(int'(wr) + int'(rd) + int'(alu) + int'(ce) + int'(fe)) <= 8'd1 ? 8'd1 : 8'd0,
                  8'd1);
        end

        // AA 05 3C with 16-cycle spacing on the long-timeout instance
        step(1, 0, 8'h00);
        check("long rst busy", {7'd0, bz2}, 8'd0);
        check("long rst wr", {7'd0, wr2}, 8'd0);
        step(0, 1, 8'hAA);
        check("long aa busy", {7'd0, bz2}, 8'd1);
        for (int k = 0; k < 15; k++) begin
            step(0, 0, 8'h00);
            check($sformatf("long gap1 c%0d busy", k), {7'd0, bz2}, 8'd1);
            check($sformatf("long gap1 c%0d strb", k), {5'd0, wr2, fe2, rd2}, 8'd0);
        end
        step(0, 1, 8'h05);
        check("long addr busy", {7'd0, bz2}, 8'd1);
        check("long addr wr", {7'd0, wr2}, 8'd0);
        for (int k = 0; k < 15; k++) begin
            step(0, 0, 8'h00);
            check($sformatf("long gap2 c%0d busy", k), {7'd0, bz2}, 8'd1);
            check($sformatf("long gap2 c%0d strb", k), {5'd0, wr2, fe2, rd2}, 8'd0);
        end
        step(0, 1, 8'h3C);
        check("long data wr", {7'd0, wr2}, 8'd1);
        check("long data addr", {4'd0, addr2}, 8'h05);
        check("long data wdata", wd2, 8'h3C);
        check("long data busy", {7'd0, bz2}, 8'd0);
        check("long data others", {5'd0, alu2, ce2, fe2}, 8'd0);
        step(0, 0, 8'h00);
        check("long post wr", {7'd0, wr2}, 8'd0);
        check("long post addr", {4'd0, addr2}, 8'h05);
        check("long post fun", {4'd0, fun2}, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rx_cmd_parser.md
Name: rx_cmd_parser

Overview:
- Sits directly downstream of the UART receiver and consumes its byte stream (P_DATA, DATA_VALID).
- Assembles multi-byte command frames and issues single-cycle register-file write/read strobes and ALU-operation requests to the system side.
- Detects unknown commands, bad addresses and stalled frames. Aborts cleanly in each case.

Parameters:
- ADDR_W, 4: register-file address width. Valid addresses are 0 .. 2^ADDR_W-1.
- TIMEOUT, 2048: maximum CLK cycles allowed between consecutive bytes of one frame.
- OPA_ADDR, 0: register-file address that receives ALU operand A.
- OPB_ADDR, 1: register-file address that receives ALU operand B.

Ports:
- CLK  in  1  system clock. Single clock domain.
- RST  in  1  synchronous, active-high reset.
- P_DATA  in  8  received byte. Valid only while DATA_VALID=1.
- DATA_VALID  in  1  one-cycle pulse per received byte.
- RF_WrEn  out  1  register-file write strobe. One-cycle pulse.
- RF_RdEn  out  1  register-file read strobe. One-cycle pulse.
- RF_Address  out  ADDR_W  address for RF_WrEn / RF_RdEn.
- RF_WrData  out  8  write data. Meaningful when RF_WrEn=1.
- ALU_EN  out  1  ALU operation strobe. One-cycle pulse.
- ALU_FUN  out  4  ALU function code. Meaningful when ALU_EN=1.
- BUSY  out  1  high while a frame is partially received.
- CMD_ERR  out  1  one-cycle pulse: unknown command byte.
- FRAME_ERR  out  1  one-cycle pulse: bad address byte or inter-byte timeout.

Behaviour:
- Reset: synchronous, active-high. Applies on any CLK edge with RST=1, including mid-frame. All outputs go to 0, state goes to IDLE, timeout counter clears.
- Frame formats (bytes in order):
  - 0xAA addr data: register write.
  - 0xBB addr: register read.
  - 0xCC opA opB fun: write operands, then run ALU.
  - 0xDD fun: run ALU on existing operands.
- FSM states: IDLE, WR_ADDR, WR_DATA, RD_ADDR, OPA, OPB, ALU_FUN.
  - IDLE + DATA_VALID:
    - AA -> WR_ADDR; BB -> RD_ADDR; CC -> OPA; DD -> ALU_FUN.
    - Any other byte -> CMD_ERR pulse next cycle, stay IDLE.
  - WR_ADDR + valid address -> latch address, go to WR_DATA.
  - WR_DATA -> RF_WrEn with the latched address and the byte, go to IDLE.
  - RD_ADDR + valid address -> RF_RdEn with that address, go to IDLE.
  - OPA -> RF_WrEn at OPA_ADDR with the byte, go to OPB.
  - OPB -> RF_WrEn at OPB_ADDR with the byte, go to ALU_FUN.
  - ALU_FUN -> ALU_EN with ALU_FUN = P_DATA[3:0], go to IDLE.
- Address check: an address byte with any bit set in [7:ADDR_W] is invalid. Result: FRAME_ERR pulse, no strobe, go to IDLE.
- Function check: ALU_FUN bytes ignore bits [7:4]. There is no error on them.
- Output latency: all outputs are registered. Strobes and error pulses appear exactly 1 cycle after the DATA_VALID cycle that caused them, for exactly 1 cycle.
- Output hold: RF_Address, RF_WrData and ALU_FUN hold their last values between strobes. They are not cleared.
- Strobe exclusivity: at most one of RF_WrEn, RF_RdEn, ALU_EN, CMD_ERR, FRAME_ERR is high in any cycle.
- BUSY: registered. It is 1 in every state except IDLE, so it rises 1 cycle after a valid command byte. It falls in the same cycle as the final strobe or FRAME_ERR.
- Timeout counter:
  - Counts cycles while not in IDLE and DATA_VALID=0.
  - Clears on every DATA_VALID and whenever in IDLE.
  - When the count reaches TIMEOUT: FRAME_ERR pulse, go to IDLE, partial frame discarded with no strobes.
  - DATA_VALID in the same cycle the count would reach TIMEOUT: the byte wins; it is processed and the counter clears.
  - Counter width is clog2(TIMEOUT+1).
- Back-to-back bytes: DATA_VALID may be high on consecutive cycles. Every byte is consumed with no drops.
- A byte arriving in the cycle right after a frame completes starts a new frame from IDLE.
- No backpressure: downstream is assumed to accept every strobe.

Test Plan:
- Register write: AA, 05, 3C with 16-cycle gaps -> single RF_WrEn with RF_Address=5, RF_WrData=0x3C, 1 cycle after the third DATA_VALID. BUSY is 1 from 1 cycle after AA until that strobe cycle.
- ALU with operands: CC, 12, 34, 0x81 back-to-back (DATA_VALID=1 for 4 consecutive cycles) ->
  - RF_WrEn addr 0 data 0x12;
  - then RF_WrEn addr 1 data 0x34;
  - then ALU_EN with ALU_FUN=1;
  - on 3 consecutive cycles, and no other strobes.
- Read and ALU-only: BB, 0F -> RF_RdEn addr 0xF. Then DD, 02 -> ALU_EN with ALU_FUN=2, and no RF_WrEn.
- Errors:
  - Byte 0x55 in IDLE -> CMD_ERR pulse, BUSY stays 0.
  - AA, 0x10 (with ADDR_W=4) -> FRAME_ERR, no RF_WrEn.
  - A following AA, 02, 7E -> normal write.
- Timeout (TIMEOUT=8):
  - AA, then silence -> FRAME_ERR exactly 8 cycles after the last DATA_VALID, BUSY drops.
  - A repeat run with the next byte landing on the terminal cycle -> no FRAME_ERR, frame continues.
- Reset mid-frame: CC, 11, then RST=1 for 1 cycle -> all outputs 0, BUSY=0. A subsequent DD, 03 -> ALU_EN with ALU_FUN=3, and no stray operand write.
